// File: rtl/cnn_pkg.sv
// Shared CNN data-path definitions: window geometry, word width, window type,
// and the RAM responder state encoding.
package cnn_pkg;

    localparam int unsigned WIN    = 5;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned IDX_W  = 3;

    typedef logic signed [DATA_W-1:0] word_t;

    // [row][col] window of signed 16-bit words
    typedef word_t [WIN-1:0][WIN-1:0] window_t;

    // WRITE_DONE is reserved; writes complete straight into DONE
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ       = 2'd1,
        WRITE_DONE = 2'd2,
        DONE       = 2'd3
    } resp_state_t;

endpackage

// File: rtl/window_addr_gen.sv
// Element address generator for a window read.
// Ports: base (window origin), stride (row pitch in words), row/col (element
// index) -> addr, the low ADDR_W bits of (base + row*stride + col) mod 2^16.
module window_addr_gen
    import cnn_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic [DATA_W-1:0] base,
    input  logic [DATA_W-1:0] stride,
    input  logic [IDX_W-1:0]  row,
    input  logic [IDX_W-1:0]  col,
    output logic [ADDR_W-1:0] addr
);

    logic [DATA_W-1:0] full_addr;

    // 16-bit arithmetic wraps naturally; truncation then wraps into the array
    always_comb begin
        full_addr = base + stride * DATA_W'(row) + DATA_W'(col);
        addr      = ADDR_W'(full_addr);
    end

endmodule

// File: rtl/ram_window_responder.sv
// Word RAM that answers DMA requests: single-word writes, or 5x5 window reads
// fetched one word per cycle (25 cycles) into a registered window.
// Ports: clk, reset (sync, active-high), RAM_enable/RAM_write request,
// RAM_address/RAM_offset (base, row stride), RAM_output_data (write data),
// RAM_input_data (read window [row][col]), RAM_finish (request complete).
module ram_window_responder
    import cnn_pkg::*;
#(
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RAM_enable,
    input  logic              RAM_write,
    input  logic [DATA_W-1:0] RAM_address,
    input  logic [DATA_W-1:0] RAM_offset,
    input  logic [DATA_W-1:0] RAM_output_data,
    output window_t           RAM_input_data,
    output logic              RAM_finish
);

    logic [DATA_W-1:0] mem [DEPTH];

    resp_state_t       state_q, state_n;
    logic [DATA_W-1:0] base_q, base_n;
    logic [DATA_W-1:0] stride_q, stride_n;
    logic [IDX_W-1:0]  row_q, row_n;
    logic [IDX_W-1:0]  col_q, col_n;
    window_t           win_n;
    logic              finish_n;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    window_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .base   (base_q),
        .stride (stride_q),
        .row    (row_q),
        .col    (col_q),
        .addr   (rd_addr)
    );

    // Combinational read so each word lands on the edge it is addressed
    assign rd_data = mem[rd_addr];

    // Next-state and output logic
    always_comb begin
        state_n   = state_q;
        base_n    = base_q;
        stride_n  = stride_q;
        row_n     = row_q;
        col_n     = col_q;
        win_n     = RAM_input_data;
        finish_n  = RAM_finish;
        mem_we    = 1'b0;
        mem_waddr = ADDR_W'(RAM_address);
        mem_wdata = RAM_output_data;

        case (state_q)
            IDLE: begin
                finish_n = 1'b0;
                if (RAM_enable) begin
                    base_n   = RAM_address;
                    stride_n = RAM_offset;
                    row_n    = '0;
                    col_n    = '0;
                    if (RAM_write) begin
                        mem_we   = 1'b1;
                        finish_n = 1'b1;
                        state_n  = DONE;
                    end else begin
                        state_n  = READ;
                    end
                end
            end
            READ: begin
                if (!RAM_enable) begin
                    // Abort: keep what was already fetched
                    state_n  = IDLE;
                    finish_n = 1'b0;
                    row_n    = '0;
                    col_n    = '0;
                end else begin
                    win_n[row_q][col_q] = rd_data;
                    if (col_q == IDX_W'(WIN - 1)) begin
                        col_n = '0;
                        if (row_q == IDX_W'(WIN - 1)) begin
                            row_n    = '0;
                            finish_n = 1'b1;
                            state_n  = DONE;
                        end else begin
                            row_n = row_q + IDX_W'(1);
                        end
                    end else begin
                        col_n = col_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                if (!RAM_enable) begin
                    finish_n = 1'b0;
                    state_n  = IDLE;
                end
            end
            default: begin
                state_n  = IDLE;
                finish_n = 1'b0;
                row_n    = '0;
                col_n    = '0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            base_q         <= '0;
            stride_q       <= '0;
            row_q          <= '0;
            col_q          <= '0;
            RAM_input_data <= '0;
            RAM_finish     <= 1'b0;
        end else begin
            state_q        <= state_n;
            base_q         <= base_n;
            stride_q       <= stride_n;
            row_q          <= row_n;
            col_q          <= col_n;
            RAM_input_data <= win_n;
            RAM_finish     <= finish_n;
        end
    end

    // Array is never reset; reset only blocks a coincident write
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_ram_window_responder.sv
// Directed self-checking bench for ram_window_responder.
module tb_ram_window_responder;
    import cnn_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        RAM_enable;
    logic        RAM_write;
    logic [15:0] RAM_address;
    logic [15:0] RAM_offset;
    logic [15:0] RAM_output_data;
    window_t     RAM_input_data;
    logic        RAM_finish;

    int total  = 0;
    int passed = 0;

    ram_window_responder #(
        .DEPTH  (4096),
        .ADDR_W (12)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .RAM_enable      (RAM_enable),
        .RAM_write       (RAM_write),
        .RAM_address     (RAM_address),
        .RAM_offset      (RAM_offset),
        .RAM_output_data (RAM_output_data),
        .RAM_input_data  (RAM_input_data),
        .RAM_finish      (RAM_finish)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
        RAM_enable = 1'b1; RAM_write = 1'b1;
        RAM_address = addr; RAM_output_data = data;
        tick();
        RAM_enable = 1'b0; RAM_write = 1'b0;
        tick();
    endtask

    // Starts a read; lat = edges after the sampling edge until finish (-1 on timeout)
    task automatic run_read(input logic [15:0] addr, input logic [15:0] off, output int lat);
        RAM_enable = 1'b1; RAM_write = 1'b0;
        RAM_address = addr; RAM_offset = off;
        tick();
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (RAM_finish === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic release_enable();
        RAM_enable = 1'b0; RAM_write = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [15:0] got;
        reset = 1'b1; RAM_enable = 1'b0; RAM_write = 1'b0;
        RAM_address = '0; RAM_offset = '0; RAM_output_data = '0;
        tick(); tick();
        total++; if (RAM_finish !== 1'b0) $display("FAIL reset_finish got %b want 0", RAM_finish); else passed++;
        total++; if (RAM_input_data !== window_t'(0)) $display("FAIL reset_window got %h want 0", RAM_input_data); else passed++;
        // Request held during reset must not be accepted
        RAM_enable = 1'b1; RAM_write = 1'b1; RAM_address = 16'd3; RAM_output_data = 16'hBEEF;
        tick();
        total++; if (RAM_finish !== 1'b0) $display("FAIL reset_priority got %b want 0", RAM_finish); else passed++;
        reset = 1'b0; RAM_enable = 1'b0; RAM_write = 1'b0;
        tick();
        got = 16'(RAM_input_data[0][0]);
        total++; if (got !== 16'h0000) $display("FAIL reset_elem00 got %h want 0000", got); else passed++;
    endtask

    task automatic test_preload_read();
        int lat;
        logic [15:0] got;
        logic [15:0] exp;
        int bad;
        for (int i = 0; i < 128; i++) do_write(16'(i), 16'(i));
        run_read(16'd10, 16'd28, lat);
        total++; if (lat !== 25) $display("FAIL preload_latency got %0d want 25", lat); else passed++;
        bad = 0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                got = 16'(RAM_input_data[r][c]);
                exp = 16'(10 + 28 * r + c);
                total++;
                if (got !== exp) begin
                    $display("FAIL preload_win[%0d][%0d] got %h want %h", r, c, got, exp);
                    bad++;
                end else passed++;
            end
        end
        release_enable();
        total++; if (RAM_finish !== 1'b0) $display("FAIL preload_release got %b want 0", RAM_finish); else passed++;
    endtask

    task automatic test_write();
        int lat;
        logic [15:0] got;
        RAM_enable = 1'b1; RAM_write = 1'b1; RAM_address = 16'd7; RAM_output_data = 16'h1234;
        tick();
        total++; if (RAM_finish !== 1'b1) $display("FAIL write_finish_high got %b want 1", RAM_finish); else passed++;
        RAM_enable = 1'b0; RAM_write = 1'b0;
        tick();
        total++; if (RAM_finish !== 1'b0) $display("FAIL write_finish_low got %b want 0", RAM_finish); else passed++;
        run_read(16'd5, 16'd1, lat);
        total++; if (lat !== 25) $display("FAIL write_rd_latency got %0d want 25", lat); else passed++;
        got = 16'(RAM_input_data[1][1]);
        total++; if (got !== 16'h1234) $display("FAIL write_readback got %h want 1234", got); else passed++;
        got = 16'(RAM_input_data[0][1]);
        total++; if (got !== 16'd6) $display("FAIL write_neighbor got %h want 0006", got); else passed++;
        release_enable();
    endtask

    task automatic test_abort();
        int lat;
        logic seen;
        logic [15:0] got;
        RAM_enable = 1'b1; RAM_write = 1'b0; RAM_address = 16'd20; RAM_offset = 16'd3;
        tick();
        seen = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (RAM_finish !== 1'b0) seen = 1'b1;
        end
        RAM_enable = 1'b0;
        tick();
        total++; if (seen !== 1'b0 || RAM_finish !== 1'b0) $display("FAIL abort_finish got %b/%b want 0/0", seen, RAM_finish); else passed++;
        got = 16'(RAM_input_data[1][3]);
        total++; if (got !== 16'd26) $display("FAIL abort_written got %h want 001a", got); else passed++;
        got = 16'(RAM_input_data[1][4]);
        total++; if (got !== 16'd10) $display("FAIL abort_unwritten got %h want 000a", got); else passed++;
        tick();
        total++; if (RAM_finish !== 1'b0) $display("FAIL abort_idle got %b want 0", RAM_finish); else passed++;
        run_read(16'd30, 16'd2, lat);
        total++; if (lat !== 25) $display("FAIL abort_next_latency got %0d want 25", lat); else passed++;
        got = 16'(RAM_input_data[4][4]);
        total++; if (got !== 16'd42) $display("FAIL abort_next_data got %h want 002a", got); else passed++;
        release_enable();
    endtask

    task automatic test_reset_mid_read();
        int lat;
        logic [15:0] got;
        logic [15:0] exp;
        RAM_enable = 1'b1; RAM_write = 1'b0; RAM_address = 16'd10; RAM_offset = 16'd28;
        tick();
        for (int i = 1; i <= 11; i++) tick();
        reset = 1'b1;
        tick();
        total++; if (RAM_finish !== 1'b0) $display("FAIL midreset_finish got %b want 0", RAM_finish); else passed++;
        total++; if (RAM_input_data !== window_t'(0)) $display("FAIL midreset_window got %h want 0", RAM_input_data); else passed++;
        reset = 1'b0; RAM_enable = 1'b0;
        tick();
        total++; if (RAM_finish !== 1'b0) $display("FAIL midreset_idle got %b want 0", RAM_finish); else passed++;
        run_read(16'd10, 16'd28, lat);
        total++; if (lat !== 25) $display("FAIL midreset_latency got %0d want 25", lat); else passed++;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                got = 16'(RAM_input_data[r][c]);
                exp = 16'(10 + 28 * r + c);
                total++;
                if (got !== exp) $display("FAIL midreset_win[%0d][%0d] got %h want %h", r, c, got, exp);
                else passed++;
            end
        end
        release_enable();
    endtask

    task automatic test_wrap();
        int lat;
        logic [15:0] got;
        run_read(16'd4094, 16'd1, lat);
        total++; if (lat !== 25) $display("FAIL wrap_latency got %0d want 25", lat); else passed++;
        got = 16'(RAM_input_data[0][2]);
        total++; if (got !== 16'd0) $display("FAIL wrap_w02 got %h want 0000", got); else passed++;
        got = 16'(RAM_input_data[0][3]);
        total++; if (got !== 16'd1) $display("FAIL wrap_w03 got %h want 0001", got); else passed++;
        got = 16'(RAM_input_data[2][2]);
        total++; if (got !== 16'd2) $display("FAIL wrap_w22 got %h want 0002", got); else passed++;
        release_enable();
        // Negative base and stride: -1 + r*(-1) + c
        run_read(16'hFFFF, 16'hFFFF, lat);
        total++; if (lat !== 25) $display("FAIL neg_latency got %0d want 25", lat); else passed++;
        got = 16'(RAM_input_data[0][1]);
        total++; if (got !== 16'd0) $display("FAIL neg_w01 got %h want 0000", got); else passed++;
        got = 16'(RAM_input_data[1][4]);
        total++; if (got !== 16'd2) $display("FAIL neg_w14 got %h want 0002", got); else passed++;
        got = 16'(RAM_input_data[2][4]);
        total++; if (got !== 16'd1) $display("FAIL neg_w24 got %h want 0001", got); else passed++;
        release_enable();
    endtask

    task automatic test_done_hold();
        int lat;
        window_t exp_w;
        logic [15:0] got;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                exp_w[r][c] = word_t'(40 + r + c);
        run_read(16'd40, 16'd1, lat);
        total++; if (lat !== 25) $display("FAIL hold_latency got %0d want 25", lat); else passed++;
        for (int j = 0; j < 5; j++) begin
            RAM_address = 16'(100 + j); RAM_write = j[0];
            RAM_offset = 16'(j * 7); RAM_output_data = 16'hFFFF;
            tick();
            total++; if (RAM_finish !== 1'b1) $display("FAIL hold_finish_%0d got %b want 1", j, RAM_finish); else passed++;
            total++; if (RAM_input_data !== exp_w) $display("FAIL hold_window_%0d got %h want %h", j, RAM_input_data, exp_w); else passed++;
        end
        release_enable();
        total++; if (RAM_finish !== 1'b0) $display("FAIL hold_release got %b want 0", RAM_finish); else passed++;
        run_read(16'd100, 16'd1, lat);
        total++; if (lat !== 25) $display("FAIL hold_reread_latency got %0d want 25", lat); else passed++;
        for (int c = 0; c < 5; c++) begin
            got = 16'(RAM_input_data[0][c]);
            total++;
            if (got !== 16'(100 + c)) $display("FAIL hold_mem[%0d] got %h want %h", 100 + c, got, 16'(100 + c));
            else passed++;
        end
        release_enable();
    endtask

    initial begin
        test_reset();
        test_preload_read();
        test_write();
        test_abort();
        test_reset_mid_read();
        test_wrap();
        test_done_hold();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ram_window_responder.md
RAM_WINDOW_RESPONDER -- requirements
Module: ram_window_responder

Interface
REQ-001 The block SHALL expose parameter DEPTH, default 4096, number of 16-bit words in the memory array (power of two).
REQ-002 The block SHALL expose parameter ADDR_W, default 12, equal to log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 RAM_enable  input  1  request valid from DMA; held high until RAM_finish is observed.
REQ-006 RAM_write  input  1  1 = single-word write, 0 = 5x5 window read; sampled with RAM_enable.
REQ-007 RAM_address  input  16  base word address (signed shortint, treated as two's-complement bits).
REQ-008 RAM_offset  input  16  row stride in words for window reads.
REQ-009 RAM_output_data  input  16  write data from DMA.
REQ-010 RAM_input_data  output  5x5x16  read window to DMA, [row][col].
REQ-011 RAM_finish  output  1  request complete; held until RAM_enable is seen low.

Function
REQ-012 The block SHALL implement FSM states IDLE, READ, WRITE_DONE, DONE.
REQ-013 In IDLE, on a posedge with RAM_enable=1, the block SHALL latch RAM_address, RAM_offset, RAM_write and RAM_output_data.
REQ-014 Write: at the sampling edge N the block SHALL store RAM_output_data at RAM_address[ADDR_W-1:0], set RAM_finish=1 and enter DONE.
REQ-015 Read: from sampling edge N the block SHALL enter READ with counter k=0; at edges N+1..N+25 it SHALL store word k (row r=k/5, col c=k%5) into RAM_input_data[r][c].
REQ-016 Element address SHALL be (address + r*offset + c) computed modulo 2^16, then truncated to the low ADDR_W bits (wrap-around, no error).
REQ-017 At edge N+25 (last word) the block SHALL set RAM_finish=1 and enter DONE; read latency is 25 cycles.
REQ-018 Memory reads SHALL be combinational from the array so each word lands the edge it is addressed.
REQ-019 In DONE, RAM_finish and RAM_input_data SHALL stay stable while RAM_enable=1.
REQ-020 In DONE, on a posedge with RAM_enable=0, the block SHALL clear RAM_finish and return to IDLE; a new request is accepted no earlier than the following edge.
REQ-021 If RAM_enable drops during READ, the block SHALL abort at that edge, return to IDLE with RAM_finish=0; already-written window elements keep their new values.
REQ-022 RAM_write, RAM_address, RAM_offset changes while not in IDLE SHALL be ignored.
REQ-023 A write to an address followed by a window read covering it SHALL return the new value.
REQ-024 WRITE_DONE SHALL be unused by default encoding but reserved; illegal states SHALL recover to IDLE.

Reset
REQ-025 On reset=1 at a posedge the block SHALL enter IDLE, clear RAM_finish to 0, clear all RAM_input_data elements to 0, and clear the counter.
REQ-026 Reset SHALL NOT clear the memory array; contents survive reset, including reset mid-READ or mid-write handshake.
REQ-027 Reset SHALL take priority over any simultaneous RAM_enable.

Structure
REQ-028 Constants WIN=5, DATA_W=16 and the 5x5 shortint window typedef SHALL live in shared package cnn_pkg, also used by the DMA.
REQ-029 Element address generation (r, c, base, stride -> ADDR_W address) SHALL be a sub-module window_addr_gen.

Verification
REQ-030 Write 0x1234 to addr 7, drop enable on finish -> finish high 1 cycle after sampling, low 1 cycle after enable low; mem[7]=0x1234.
REQ-031 Preload mem[i]=i via writes for i=0..127; read addr 10 offset 28 -> finish at edge N+25, window[r][c]=10+28r+c.
REQ-032 Read addr DEPTH-2 offset 1 -> window[0][2]=mem[0] (wrap-around).
REQ-033 Drop enable at edge N+10 of a read -> FSM IDLE, finish never asserted; next read completes normally.
REQ-034 Assert reset at edge N+12 of a read -> window all 0, finish 0; subsequent read returns preloaded values unchanged.
REQ-035 Hold enable high in DONE for 5 cycles with changing address/write inputs -> finish and window stable, no memory change.
